// File: rtl/bignum_word_ram_if.sv
// Request/response bundle between the bignum word RAM and its requesters
// (bignum adder read/write loop plus host preload/readback port).
interface bignum_word_ram_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  request_valid_in;
    logic [ADDR_WIDTH-1:0] x_request_in;
    logic [ADDR_WIDTH-1:0] y_request_in;
    logic                  received_valid_out;
    logic [DATA_WIDTH-1:0] x_data_out;
    logic [DATA_WIDTH-1:0] y_data_out;

    logic                  valid_write_in;
    logic [DATA_WIDTH-1:0] data_to_store_in;
    logic [ADDR_WIDTH-1:0] write_data_pointer_in;

    logic                  host_wr_valid_in;
    logic                  host_wr_ready_out;
    logic [ADDR_WIDTH-1:0] host_wr_addr_in;
    logic [DATA_WIDTH-1:0] host_wr_data_in;

    logic                  host_rd_valid_in;
    logic                  host_rd_ready_out;
    logic [ADDR_WIDTH-1:0] host_rd_addr_in;
    logic                  host_rd_valid_out;
    logic [DATA_WIDTH-1:0] host_rd_data_out;

    modport master (
        output request_valid_in, x_request_in, y_request_in,
        input  received_valid_out, x_data_out, y_data_out,
        output valid_write_in, data_to_store_in, write_data_pointer_in,
        output host_wr_valid_in, host_wr_addr_in, host_wr_data_in,
        input  host_wr_ready_out,
        output host_rd_valid_in, host_rd_addr_in,
        input  host_rd_ready_out, host_rd_valid_out, host_rd_data_out
    );

    modport slave (
        input  request_valid_in, x_request_in, y_request_in,
        output received_valid_out, x_data_out, y_data_out,
        input  valid_write_in, data_to_store_in, write_data_pointer_in,
        input  host_wr_valid_in, host_wr_addr_in, host_wr_data_in,
        output host_wr_ready_out,
        input  host_rd_valid_in, host_rd_addr_in,
        output host_rd_ready_out, host_rd_valid_out, host_rd_data_out
    );
endinterface

// File: rtl/bignum_word_ram.sv
// Dual-copy word store for the bignum adder with a host preload/readback port.
// Define WORD_RAM_WR_BYPASS_EN to forward same-cycle write data to colliding reads.
module bignum_word_ram #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input logic            clk_in,
    input logic            rst_in,
    bignum_word_ram_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_x [DEPTH];
    logic [DATA_WIDTH-1:0] mem_y [DEPTH];

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_adder;
    logic                  rd_host;
    logic [ADDR_WIDTH-1:0] rd_x_addr;
    logic [DATA_WIDTH-1:0] rd_x;
    logic [DATA_WIDTH-1:0] rd_y;

    logic [READ_LATENCY-1:0] tag_a;
    logic [READ_LATENCY-1:0] tag_h;
    logic [DATA_WIDTH-1:0]   px [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   py [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   ph [READ_LATENCY];

    // Adder always wins both the write and the read port.
    always_comb begin
        wr_en     = bus.valid_write_in | bus.host_wr_valid_in;
        wr_addr   = bus.valid_write_in ? bus.write_data_pointer_in
                                       : bus.host_wr_addr_in;
        wr_data   = bus.valid_write_in ? bus.data_to_store_in
                                       : bus.host_wr_data_in;
        rd_adder  = bus.request_valid_in;
        rd_host   = bus.host_rd_valid_in & ~bus.request_valid_in;
        rd_x_addr = rd_adder ? bus.x_request_in : bus.host_rd_addr_in;
        rd_x      = mem_x[rd_x_addr];
        rd_y      = mem_y[bus.y_request_in];
`ifdef WORD_RAM_WR_BYPASS_EN
        if (wr_en && wr_addr == rd_x_addr)
            rd_x = wr_data;
        if (wr_en && wr_addr == bus.y_request_in)
            rd_y = wr_data;
`endif
    end

    assign bus.host_wr_ready_out = ~bus.valid_write_in;
    assign bus.host_rd_ready_out = ~bus.request_valid_in;

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_x[wr_addr] <= wr_data;
            mem_y[wr_addr] <= wr_data;
        end
    end

    // Data stages only advance behind a valid tag, so the last stage
    // holds the most recent read between strobes.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tag_a <= '0;
            tag_h <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                px[i] <= '0;
                py[i] <= '0;
                ph[i] <= '0;
            end
        end else begin
            tag_a[0] <= rd_adder;
            tag_h[0] <= rd_host;
            if (rd_adder) begin
                px[0] <= rd_x;
                py[0] <= rd_y;
            end
            if (rd_host)
                ph[0] <= rd_x;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_a[i] <= tag_a[i-1];
                tag_h[i] <= tag_h[i-1];
                if (tag_a[i-1]) begin
                    px[i] <= px[i-1];
                    py[i] <= py[i-1];
                end
                if (tag_h[i-1])
                    ph[i] <= ph[i-1];
            end
        end
    end

    assign bus.received_valid_out = tag_a[READ_LATENCY-1];
    assign bus.x_data_out         = px[READ_LATENCY-1];
    assign bus.y_data_out         = py[READ_LATENCY-1];
    assign bus.host_rd_valid_out  = tag_h[READ_LATENCY-1];
    assign bus.host_rd_data_out   = ph[READ_LATENCY-1];
endmodule

// File: tb/tb_bignum_word_ram.sv
// Scoreboard bench for bignum_word_ram: directed adder/host traffic,
// expected words and strobe cycles queued at issue, checked by a monitor.
module tb_bignum_word_ram;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int RL = 2;

`ifdef WORD_RAM_WR_BYPASS_EN
    localparam logic [31:0] BYP = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] BYP = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bignum_word_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bignum_word_ram #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        int          at;
    } exp_t;

    exp_t qa[$];
    exp_t qh[$];
    exp_t ea;
    exp_t eh;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.received_valid_out === 1'b1) begin
            if (qa.size() == 0) begin
                chk("adder_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                ea = qa.pop_front();
                chk("adder_cycle", cyc, ea.at);
                chk("x_data", bus.x_data_out, ea.x);
                chk("y_data", bus.y_data_out, ea.y);
            end
        end
        if (bus.host_rd_valid_out === 1'b1) begin
            if (qh.size() == 0) begin
                chk("host_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                eh = qh.pop_front();
                chk("host_cycle", cyc, eh.at);
                chk("host_data", bus.host_rd_data_out, eh.x);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.request_valid_in      = 1'b0;
        bus.x_request_in          = '0;
        bus.y_request_in          = '0;
        bus.valid_write_in        = 1'b0;
        bus.data_to_store_in      = '0;
        bus.write_data_pointer_in = '0;
        bus.host_wr_valid_in      = 1'b0;
        bus.host_wr_addr_in       = '0;
        bus.host_wr_data_in       = '0;
        bus.host_rd_valid_in      = 1'b0;
        bus.host_rd_addr_in       = '0;
    endtask

    task automatic host_wr(logic [7:0] a, logic [31:0] d);
        bus.host_wr_valid_in = 1'b1;
        bus.host_wr_addr_in  = a;
        bus.host_wr_data_in  = d;
        tick();
        bus.host_wr_valid_in = 1'b0;
    endtask

    task automatic push_a(logic [31:0] x, logic [31:0] y);
        exp_t e;
        e.x  = x;
        e.y  = y;
        e.at = cyc + RL;
        qa.push_back(e);
    endtask

    task automatic adder_rd(logic [7:0] xa, logic [7:0] ya,
                            logic [31:0] ex, logic [31:0] ey);
        bus.request_valid_in = 1'b1;
        bus.x_request_in     = xa;
        bus.y_request_in     = ya;
        push_a(ex, ey);
        tick();
        bus.request_valid_in = 1'b0;
    endtask

    function automatic logic [31:0] pat(int i);
        logic [31:0] v;
        v = 32'hC0DE_0000 + 32'(i);
        return v;
    endfunction

    task automatic check_idle_outputs(string tag);
        chk({tag, "_recv_valid"}, 32'(bus.received_valid_out), 32'd0);
        chk({tag, "_host_valid"}, 32'(bus.host_rd_valid_out), 32'd0);
        chk({tag, "_x_data"}, bus.x_data_out, 32'd0);
        chk({tag, "_y_data"}, bus.y_data_out, 32'd0);
        chk({tag, "_host_data"}, bus.host_rd_data_out, 32'd0);
    endtask

    initial begin
        exp_t e;
        idle();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check_idle_outputs("reset");
        chk("reset_wr_ready", 32'(bus.host_wr_ready_out), 32'd1);
        chk("reset_rd_ready", 32'(bus.host_rd_ready_out), 32'd1);
        tick();

        // Preload and paired adder read; host read collides and is held.
        host_wr(8'd5, 32'h0000_0001);
        host_wr(8'd69, 32'hFFFF_FFFF);
        bus.request_valid_in = 1'b1;
        bus.x_request_in     = 8'd5;
        bus.y_request_in     = 8'd69;
        bus.host_rd_valid_in = 1'b1;
        bus.host_rd_addr_in  = 8'd5;
        push_a(32'h0000_0001, 32'hFFFF_FFFF);
        #1;
        chk("host_rd_ready_busy", 32'(bus.host_rd_ready_out), 32'd0);
        tick();
        bus.request_valid_in = 1'b0;
        #1;
        chk("host_rd_ready_free", 32'(bus.host_rd_ready_out), 32'd1);
        e.x  = 32'h0000_0001;
        e.y  = '0;
        e.at = cyc + RL;
        qh.push_back(e);
        tick();
        bus.host_rd_valid_in = 1'b0;

        // Adder write beats host write to the same address.
        bus.valid_write_in        = 1'b1;
        bus.write_data_pointer_in = 8'd130;
        bus.data_to_store_in      = 32'hA5A5_A5A5;
        bus.host_wr_valid_in      = 1'b1;
        bus.host_wr_addr_in       = 8'd130;
        bus.host_wr_data_in       = 32'h0000_1234;
        #1;
        chk("host_wr_ready_busy", 32'(bus.host_wr_ready_out), 32'd0);
        tick();
        idle();
        adder_rd(8'd130, 8'd130, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        #1;
        chk("host_wr_ready_free", 32'(bus.host_wr_ready_out), 32'd1);
        host_wr(8'd130, 32'h0000_1234);
        adder_rd(8'd130, 8'd130, 32'h0000_1234, 32'h0000_1234);

        // Same-cycle write and read of one address.
        host_wr(8'd7, 32'h0000_0000);
        bus.valid_write_in        = 1'b1;
        bus.write_data_pointer_in = 8'd7;
        bus.data_to_store_in      = 32'hDEAD_BEEF;
        bus.request_valid_in      = 1'b1;
        bus.x_request_in          = 8'd7;
        bus.y_request_in          = 8'd7;
        push_a(BYP, BYP);
        tick();
        idle();
        adder_rd(8'd7, 8'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // 64 back-to-back adder pairs.
        for (int i = 0; i < 64; i++)
            host_wr(8'(i), pat(i));
        for (int i = 0; i < 64; i++) begin
            bus.request_valid_in = 1'b1;
            bus.x_request_in     = 8'(63 - i);
            bus.y_request_in     = 8'(i);
            push_a(pat(63 - i), pat(i));
            tick();
        end
        bus.request_valid_in = 1'b0;

        for (int k = 0; k < 20 && (qa.size() != 0 || qh.size() != 0); k++)
            tick();
        chk("drain_adder_queue", 32'(qa.size()), 32'd0);
        chk("drain_host_queue", 32'(qh.size()), 32'd0);

        // Reset while a read is in flight: its strobe must never appear.
        bus.request_valid_in = 1'b1;
        bus.x_request_in     = 8'd1;
        bus.y_request_in     = 8'd2;
        tick();
        bus.request_valid_in = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (6) tick();
        chk("midreset_no_strobe", 32'(bus.received_valid_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bignum_word_ram.md
# bignum_word_ram

Dual-copy 32-bit word store that serves the bignum adder: answers its paired x/y read requests with fixed latency, absorbs its result writes, and exposes a host port for preloading operands and reading back results. Sits directly beside the adder, closing its request/receive/write loop; the host side (UART/test driver) connects to the same instance.

## Interface
Parameters:
- ADDR_WIDTH, 8, word address width; depth = 2**ADDR_WIDTH words (256 → four 2048-bit numbers of 64 words).
- DATA_WIDTH, 32, word width.
- READ_LATENCY, 2, cycles from accepted read to data valid; legal 1..4.

Ports:
- clk_in  in  1  system clock; all state on rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- request_valid_in  in  1  adder read request (one cycle pulse per pair).
- x_request_in  in  ADDR_WIDTH  x word address.
- y_request_in  in  ADDR_WIDTH  y word address.
- received_valid_out  out  1  x/y data valid strobe to adder.
- x_data_out  out  DATA_WIDTH  word at x address.
- y_data_out  out  DATA_WIDTH  word at y address.
- valid_write_in  in  1  adder write strobe.
- data_to_store_in  in  DATA_WIDTH  adder write data.
- write_data_pointer_in  in  ADDR_WIDTH  adder write address.
- host_wr_valid_in / host_wr_ready_out  in/out  1/1  host write handshake.
- host_wr_addr_in, host_wr_data_in  in  ADDR_WIDTH, DATA_WIDTH  host write address/data.
- host_rd_valid_in / host_rd_ready_out  in/out  1/1  host read handshake.
- host_rd_addr_in  in  ADDR_WIDTH  host read address.
- host_rd_valid_out  out  1  host read data strobe.
- host_rd_data_out  out  DATA_WIDTH  host read data.

## Operation
- Two RAM copies (X, Y), each one write + one read port; every accepted write goes to both copies at the same address.
- Write arbitration per cycle: adder write (valid_write_in) wins; host_wr_ready_out = !valid_write_in. Host write accepted when host_wr_valid_in && host_wr_ready_out. Adder writes are never stalled or dropped.
- Read arbitration per cycle: adder read wins; host_rd_ready_out = !request_valid_in. Adder read uses X port with x_request_in and Y port with y_request_in; host read uses X port only.
- Tag pipeline: READ_LATENCY-deep shift register of {adder_valid, host_valid}; stage 0 loaded at acceptance; last stage drives received_valid_out / host_rd_valid_out. Each accepted read yields exactly one strobe, in order.
- Data outputs hold last read value between strobes; x_data_out and host_rd_data_out share the X read path.
- Address arithmetic: addresses used as-is, no wrap logic; out-of-range impossible by width.
- No backpressure toward adder: adder must accept received_valid_out when it comes.

## Timing
- Reset (async assert, sync release): received_valid_out=0, host_rd_valid_out=0, tag pipeline cleared, x_data_out=y_data_out=host_rd_data_out=0, host_wr_ready_out and host_rd_ready_out follow comb equations (1 when adder idle). RAM contents undefined after reset, not cleared.
- Reset mid-read: all in-flight strobes dropped; no strobe appears after reset deasserts for pre-reset requests.
- Read accepted cycle T → strobe and data in cycle T+READ_LATENCY, single cycle high.
- Back-to-back reads every cycle sustained; throughput one adder pair or one host word per cycle.
- Write accepted cycle T visible to any read accepted in T+1 or later.
- Same-cycle read and write to same address: see Configuration.
- Simultaneous adder read + host read: host ready low, host must hold request; adder served.
- Simultaneous adder write + host write: host held; both copies receive adder data only.

## Configuration
- WORD_RAM_WR_BYPASS_EN defined: a read accepted in the same cycle as a write to a matching address returns the newly written data (per-port compare, X and Y independently; host read also bypassed).
- Undefined: same-cycle collision returns old RAM contents (read-before-write); write still lands.

## Test plan
- Host writes 0x0000_0001 to addr 5, 0xFFFF_FFFF to addr 69; adder request x=5,y=69 at T → received_valid_out at T+2 with x=0x1, y=0xFFFF_FFFF.
- Host read addr 5 while request_valid_in high → host_rd_ready_out=0; next cycle accepted, host_rd_valid_out two cycles later with 0x1; adder strobe unaffected.
- Adder write 0xA5A5_A5A5 to addr 130 concurrent with host write 0x1234 to 130 → host_wr_ready_out=0, both copies read back 0xA5A5_A5A5; host write lands next cycle.
- Same-cycle write 0xDEAD_BEEF to addr 7 and adder read x=7 (old 0x0) → x_data_out=0xDEAD_BEEF with WORD_RAM_WR_BYPASS_EN, 0x0 without.
- 64 consecutive adder requests (addr 63 down to 0) → 64 consecutive strobes, correct words, in order.
- Assert rst_in one cycle after request → no received_valid_out afterwards; outputs 0.
